wavetable_reader: RTL and testbench

- Per-sample sequencer that services a bank of NCO voices. The NCOs produce wavetable phase (PHASE) on TRIG_READ and capture a scaled sample on TRIG_SAMPLE.
- On each SAMPLE_TICK the block walks the voices in order:
  - strobes TRIG_READ for the voice;
  - reads the selected voice's PHASE;
  - fetches the waveform byte from synchronous wavetable ROM;
  - presents it on PROG_SAMPLE and strobes TRIG_SAMPLE.
- Sits between the voice NCO array and the wavetable ROM. It is the read-side counterpart that drives the NCO strobe interface.

---
 rtl/wavetable_reader_pkg.sv | 38 +++
 rtl/wavetable_reader_if.sv | 49 ++++
 rtl/wavetable_reader_reg.sv | 31 +++
 rtl/wavetable_reader.sv | 163 ++++++++++++++++
 tb/tb_wavetable_reader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wavetable_reader_pkg.sv
// -----------------------------------------------------------------------------
// wavetable_reader_pkg
// Shared definitions for the wavetable reader and its interface:
//   - state_t        : sequencer state encoding
//   - DEF_PHASE_W    : default NCO phase width (shared with the NCO array)
//   - DEF_SAMPLE_W   : default wavetable sample width (shared with the NCO array)
//   - clog2()        : ceiling log2 for elaboration-time sizing
//   - sel_width()    : voice-index width, never less than one bit
// -----------------------------------------------------------------------------
package wavetable_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_ADDR  = 3'd2,
        S_WAIT  = 3'd3,
        S_LOAD  = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    localparam int DEF_PHASE_W  = 8;
    localparam int DEF_SAMPLE_W = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // A single-voice configuration still needs a 1-bit index bus.
    function automatic int sel_width(input int voices);
        return (voices > 1) ? clog2(voices) : 1;
    endfunction

endpackage

// File: rtl/wavetable_reader_if.sv
// -----------------------------------------------------------------------------
// wavetable_reader_if
// Bundles the reader's control inputs, the NCO strobe bus and the ROM port.
//   ce, sample_tick, wave_sel, voice_en  : frame control into the reader
//   phase_in                            : PHASE of the selected voice
//   rom_data / rom_addr                 : synchronous wavetable ROM port
//   voice_sel, trig_read, trig_sample,
//   prog_sample                         : NCO strobe interface
//   busy, done, overrun                 : frame status
// Modports: master = the reader, slave = the NCO array / ROM / controller side.
// -----------------------------------------------------------------------------
interface wavetable_reader_if
    import wavetable_reader_pkg::*;
#(
    parameter int VOICES   = 8,
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int WAVE_W   = 2,
    parameter int SAMPLE_W = DEF_SAMPLE_W
);
    localparam int VSEL_W = sel_width(VOICES);

    logic                       ce;
    logic                       sample_tick;
    logic [WAVE_W-1:0]          wave_sel;
    logic [VOICES-1:0]          voice_en;
    logic [PHASE_W-1:0]         phase_in;
    logic [SAMPLE_W-1:0]        rom_data;
    logic [VSEL_W-1:0]          voice_sel;
    logic [VOICES-1:0]          trig_read;
    logic [VOICES-1:0]          trig_sample;
    logic [WAVE_W+PHASE_W-1:0]  rom_addr;
    logic [SAMPLE_W-1:0]        prog_sample;
    logic                       busy;
    logic                       done;
    logic                       overrun;

    modport master (
        input  ce, sample_tick, wave_sel, voice_en, phase_in, rom_data,
        output voice_sel, trig_read, trig_sample, rom_addr, prog_sample,
               busy, done, overrun
    );

    modport slave (
        output ce, sample_tick, wave_sel, voice_en, phase_in, rom_data,
        input  voice_sel, trig_read, trig_sample, rom_addr, prog_sample,
               busy, done, overrun
    );

endinterface

// File: rtl/wavetable_reader_reg.sv
// -----------------------------------------------------------------------------
// wavetable_reader_reg
// Generic load-enabled register with synchronous active-high clear.
//   i_clk : clock
//   i_rst : synchronous clear to zero
//   i_en  : load enable
//   i_d   : data in
//   o_q   : registered data, holds while i_en is low
// -----------------------------------------------------------------------------
module wavetable_reader_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wavetable_reader.sv
// -----------------------------------------------------------------------------
// wavetable_reader
// Per-sample sequencer for a bank of NCO voices. On each sample tick it walks
// the voices in order: strobes TRIG_READ for the voice, captures its phase
// into the ROM address register, waits out the ROM latency, loads the ROM
// byte into PROG_SAMPLE and strobes TRIG_SAMPLE. Disabled voices are skipped
// in one cycle.
//   i_clk : system clock
//   i_rst : synchronous active-high reset (aborts any frame in progress)
//   bus   : wavetable_reader_if.master (control, ROM port, NCO strobes, status)
// -----------------------------------------------------------------------------
module wavetable_reader
    import wavetable_reader_pkg::*;
#(
    parameter int VOICES   = 8,
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int WAVE_W   = 2,
    parameter int ROM_LAT  = 1,
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    wavetable_reader_if.master bus
);
    localparam int VSEL_W = sel_width(VOICES);
    localparam int ADDR_W = WAVE_W + PHASE_W;

    state_t              r_state;
    logic [VSEL_W-1:0]   r_vidx;
    logic [WAVE_W-1:0]   r_wave;
    logic [VOICES-1:0]   r_en;
    logic [1:0]          r_cnt;
    logic [VOICES-1:0]   r_trig_read;
    logic [VOICES-1:0]   r_trig_sample;
    logic                r_done;
    logic                r_overrun;

    logic [VSEL_W-1:0]   w_vidx_nxt;
    logic                w_last;
    logic                w_addr_en;
    logic                w_samp_en;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic [SAMPLE_W-1:0] w_prog_sample;

    function automatic logic [VOICES-1:0] f_onehot(input logic [VSEL_W-1:0] idx);
        return VOICES'(1) << idx;
    endfunction

    // Strobe pattern for entering STEP of voice idx: disabled voices get none.
    function automatic logic [VOICES-1:0] f_read_strobe(input logic [VOICES-1:0] en,
                                                        input logic [VSEL_W-1:0] idx);
        return en[idx] ? f_onehot(idx) : '0;
    endfunction

    assign w_vidx_nxt = r_vidx + 1'b1;
    assign w_last     = (r_vidx == VSEL_W'(VOICES - 1));

    // Strobe and DONE registers are loaded for the state being entered, so
    // they line up with that state's cycle. When CE is low nothing advances
    // and the strobe registers hold; the output gating below hides them
    // until CE returns, at which point the state finally moves on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_vidx        <= '0;
            r_cnt         <= '0;
            r_trig_read   <= '0;
            r_trig_sample <= '0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
        end else if (bus.ce) begin
            r_trig_read   <= '0;
            r_trig_sample <= '0;
            r_done        <= 1'b0;

            if (bus.sample_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.sample_tick) begin
                        r_wave      <= bus.wave_sel;
                        r_en        <= bus.voice_en;
                        r_vidx      <= '0;
                        r_state     <= S_STEP;
                        r_trig_read <= f_read_strobe(bus.voice_en, '0);
                    end
                end
                S_STEP: begin
                    if (r_en[r_vidx]) begin
                        r_state <= S_ADDR;
                    end else if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_vidx      <= w_vidx_nxt;
                        r_trig_read <= f_read_strobe(r_en, w_vidx_nxt);
                    end
                end
                S_ADDR: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 2'(ROM_LAT - 1)) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state       <= S_WRITE;
                    r_trig_sample <= f_onehot(r_vidx);
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_vidx      <= w_vidx_nxt;
                        r_state     <= S_STEP;
                        r_trig_read <= f_read_strobe(r_en, w_vidx_nxt);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ADDR: the NCO has advanced on the previous TRIG_READ, so PHASE_IN is
    // already the post-increment phase.
    assign w_addr_en = bus.ce && (r_state == S_ADDR);
    assign w_samp_en = bus.ce && (r_state == S_LOAD);

    wavetable_reader_reg #(.W(ADDR_W)) u_rom_addr_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_addr_en),
        .i_d   ({r_wave, bus.phase_in}),
        .o_q   (w_rom_addr)
    );

    wavetable_reader_reg #(.W(SAMPLE_W)) u_prog_sample_reg (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_samp_en),
        .i_d   (bus.rom_data),
        .o_q   (w_prog_sample)
    );

    assign bus.voice_sel   = r_vidx;
    assign bus.trig_read   = bus.ce ? r_trig_read   : '0;
    assign bus.trig_sample = bus.ce ? r_trig_sample : '0;
    assign bus.done        = bus.ce & r_done;
    assign bus.rom_addr    = w_rom_addr;
    assign bus.prog_sample = w_prog_sample;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_wavetable_reader.sv
// -----------------------------------------------------------------------------
// tb_wavetable_reader
// Two reader instances (8 voices and 2 voices, ROM_LAT=1) with a behavioural
// one-cycle ROM each. Table-driven frames on the 8-voice instance, plus
// hand-written sequences for overrun, CE stalls, exact 2-voice strobe timing
// and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_wavetable_reader;
    import wavetable_reader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wavetable_reader_if #(.VOICES(8), .PHASE_W(8), .WAVE_W(2), .SAMPLE_W(8)) bus8 ();
    wavetable_reader_if #(.VOICES(2), .PHASE_W(8), .WAVE_W(2), .SAMPLE_W(8)) bus2 ();

    wavetable_reader #(.VOICES(8), .PHASE_W(8), .WAVE_W(2), .ROM_LAT(1), .SAMPLE_W(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8)
    );

    wavetable_reader #(.VOICES(2), .PHASE_W(8), .WAVE_W(2), .ROM_LAT(1), .SAMPLE_W(8)) dut2 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus2)
    );

    function automatic logic [7:0] rom_f(input logic [9:0] a);
        if (a == 10'h23C) return 8'hA5;
        return a[7:0] ^ 8'h5A ^ {6'b0, a[9:8]};
    endfunction

    // Synchronous ROM, one cycle from address register to data.
    always @(posedge clk) begin
        bus8.rom_data <= rom_f(bus8.rom_addr);
        bus2.rom_data <= rom_f(bus2.rom_addr);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame on the 8-voice instance in the current cycle (cycle 0)
    // and runs until DONE. Optional extra tick at cycle tick2_at, optional CE
    // low for ce_lo_len cycles from cycle ce_lo_at. viol counts strobe-rule
    // breaks: strobes/DONE while CE low, both strobes together, more than one
    // bit hot, or a voice strobed twice.
    task automatic run_frame(input logic [7:0] en, input logic [1:0] wave,
                             input logic [7:0] phase, input int tick2_at,
                             input int ce_lo_at, input int ce_lo_len,
                             output int done_cyc, output logic [7:0] rmask,
                             output logic [7:0] smask, output int viol);
        done_cyc = -1;
        rmask    = '0;
        smask    = '0;
        viol     = 0;
        bus8.voice_en    = en;
        bus8.wave_sel    = wave;
        bus8.phase_in    = phase;
        bus8.ce          = 1'b1;
        bus8.sample_tick = 1'b1;
        next_cycle();
        for (int c = 1; c < 200; c++) begin
            bus8.sample_tick = (c == tick2_at);
            bus8.ce          = !((c >= ce_lo_at) && (c < ce_lo_at + ce_lo_len));
            #1;
            if (!bus8.ce && ((bus8.trig_read != 0) || (bus8.trig_sample != 0) || bus8.done)) viol++;
            if ((bus8.trig_read != 0) && (bus8.trig_sample != 0)) viol++;
            if (($countones(bus8.trig_read) > 1) || ($countones(bus8.trig_sample) > 1)) viol++;
            if (((rmask & bus8.trig_read) != 0) || ((smask & bus8.trig_sample) != 0)) viol++;
            rmask = rmask | bus8.trig_read;
            smask = smask | bus8.trig_sample;
            if (bus8.done) begin
                done_cyc = c;
                break;
            end
            next_cycle();
        end
        bus8.sample_tick = 1'b0;
        bus8.ce          = 1'b1;
    endtask

    typedef struct {
        logic [7:0] en;
        logic [1:0] wave;
        logic [7:0] phase;
        int         done_cyc;
        logic [9:0] addr;
        logic [7:0] prog;
    } vec_t;

    vec_t       vt [5];
    int         dc;
    int         vl;
    logic [7:0] rm;
    logic [7:0] sm;
    int         tr0, ts0, tr1, ts1, dn;
    logic       bz;
    logic [7:0] ps;
    logic [9:0] pa;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {en, wave, phase, DONE cycle, ROM_ADDR at DONE, PROG_SAMPLE at DONE}
        vt[0] = '{8'h05, 2'b10, 8'h3C, 17, 10'h23C, 8'hA5};
        vt[1] = '{8'hFF, 2'b00, 8'h00, 41, 10'h000, 8'h5A};
        vt[2] = '{8'h80, 2'b01, 8'hFF, 13, 10'h1FF, 8'hA4};
        vt[3] = '{8'h00, 2'b11, 8'h11,  9, 10'h1FF, 8'hA4};
        vt[4] = '{8'h42, 2'b11, 8'h80, 17, 10'h380, 8'hD9};

        rst = 1'b1;
        bus8.ce = 1'b1; bus8.sample_tick = 1'b0; bus8.voice_en = '0;
        bus8.wave_sel = '0; bus8.phase_in = '0;
        bus2.ce = 1'b1; bus2.sample_tick = 1'b0; bus2.voice_en = 2'b11;
        bus2.wave_sel = 2'b10; bus2.phase_in = 8'h3C;
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;
        check("rst busy",        32'(bus8.busy),        32'h0);
        check("rst voice_sel",   32'(bus8.voice_sel),   32'h0);
        check("rst rom_addr",    32'(bus8.rom_addr),    32'h0);
        check("rst prog_sample", 32'(bus8.prog_sample), 32'h0);
        check("rst overrun",     32'(bus8.overrun),     32'h0);
        check("rst trig_read",   32'(bus8.trig_read),   32'h0);
        check("rst trig_sample", 32'(bus8.trig_sample), 32'h0);
        check("rst done",        32'(bus8.done),        32'h0);
        next_cycle();

        // Back-to-back frames: each new tick lands in the previous DONE cycle.
        for (int i = 0; i < 5; i++) begin
            run_frame(vt[i].en, vt[i].wave, vt[i].phase, -1, -1, 0, dc, rm, sm, vl);
            check($sformatf("vec%0d done_cycle", i), 32'(dc), 32'(vt[i].done_cyc));
            check($sformatf("vec%0d read_mask", i), 32'(rm), 32'(vt[i].en));
            check($sformatf("vec%0d sample_mask", i), 32'(sm), 32'(vt[i].en));
            check($sformatf("vec%0d strobe_rules", i), 32'(vl), 32'h0);
            check($sformatf("vec%0d rom_addr", i), 32'(bus8.rom_addr), 32'(vt[i].addr));
            check($sformatf("vec%0d prog_sample", i), 32'(bus8.prog_sample), 32'(vt[i].prog));
            check($sformatf("vec%0d voice_sel", i), 32'(bus8.voice_sel), 32'h7);
            check($sformatf("vec%0d busy_at_done", i), 32'(bus8.busy), 32'h0);
            check($sformatf("vec%0d overrun", i), 32'(bus8.overrun), 32'h0);
        end
        next_cycle();
        next_cycle();

        // Extra tick 3 cycles into a frame: frame unaffected, overrun sticky,
        // and a tick in the DONE cycle still starts the next frame.
        run_frame(8'h05, 2'b10, 8'h3C, 3, -1, 0, dc, rm, sm, vl);
        check("ovr done_cycle", 32'(dc), 32'd17);
        check("ovr read_mask",  32'(rm), 32'h05);
        check("ovr strobe_rules", 32'(vl), 32'h0);
        check("ovr overrun",    32'(bus8.overrun), 32'h1);
        run_frame(8'h05, 2'b10, 8'h3C, -1, -1, 0, dc, rm, sm, vl);
        check("ovr2 done_cycle", 32'(dc), 32'd17);
        check("ovr2 read_mask",  32'(rm), 32'h05);
        check("ovr2 strobe_rules", 32'(vl), 32'h0);
        check("ovr2 overrun",    32'(bus8.overrun), 32'h1);

        // CE low 4 cycles in WAIT of voice 0, then CE low 2 cycles in STEP.
        run_frame(8'h05, 2'b10, 8'h3C, -1, 3, 4, dc, rm, sm, vl);
        check("ce_wait done_cycle", 32'(dc), 32'd21);
        check("ce_wait read_mask",  32'(rm), 32'h05);
        check("ce_wait sample_mask", 32'(sm), 32'h05);
        check("ce_wait strobe_rules", 32'(vl), 32'h0);
        run_frame(8'h05, 2'b10, 8'h3C, -1, 1, 2, dc, rm, sm, vl);
        check("ce_step done_cycle", 32'(dc), 32'd19);
        check("ce_step read_mask",  32'(rm), 32'h05);
        check("ce_step sample_mask", 32'(sm), 32'h05);
        check("ce_step strobe_rules", 32'(vl), 32'h0);

        // Exact strobe timing on the 2-voice instance.
        tr0 = -1; ts0 = -1; tr1 = -1; ts1 = -1; dn = -1; bz = 1'bx;
        ps = '0; pa = '0;
        bus2.sample_tick = 1'b1;
        next_cycle();
        bus2.sample_tick = 1'b0;
        for (int c = 1; c < 40; c++) begin
            #1;
            if (bus2.trig_read[0]   && tr0 < 0) tr0 = c;
            if (bus2.trig_read[1]   && tr1 < 0) tr1 = c;
            if (bus2.trig_sample[0] && ts0 < 0) begin
                ts0 = c;
                ps  = bus2.prog_sample;
                pa  = bus2.rom_addr;
            end
            if (bus2.trig_sample[1] && ts1 < 0) ts1 = c;
            if (bus2.done) begin
                dn = c;
                bz = bus2.busy;
                break;
            end
            next_cycle();
        end
        check("v2 trig_read0 cycle",   32'(tr0), 32'd1);
        check("v2 trig_sample0 cycle", 32'(ts0), 32'd5);
        check("v2 trig_read1 cycle",   32'(tr1), 32'd6);
        check("v2 trig_sample1 cycle", 32'(ts1), 32'd10);
        check("v2 done cycle",         32'(dn),  32'd11);
        check("v2 busy at done",       32'(bz),  32'h0);
        check("v2 prog at trig_sample", 32'(ps), 32'hA5);
        check("v2 addr at trig_sample", 32'(pa), 32'h23C);

        // Reset pulse during WRITE of voice 1.
        bus2.sample_tick = 1'b1;
        next_cycle();
        bus2.sample_tick = 1'b0;
        repeat (9) next_cycle();
        #1;
        check("rstmid trig_sample pre", 32'(bus2.trig_sample), 32'h2);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rstmid trig_read",   32'(bus2.trig_read),   32'h0);
        check("rstmid trig_sample", 32'(bus2.trig_sample), 32'h0);
        check("rstmid busy",        32'(bus2.busy),        32'h0);
        check("rstmid prog_sample", 32'(bus2.prog_sample), 32'h0);
        check("rstmid rom_addr",    32'(bus2.rom_addr),    32'h0);
        check("rstmid done",        32'(bus2.done),        32'h0);
        check("rstmid overrun8",    32'(bus8.overrun),     32'h0);
        next_cycle();
        check("rstmid done after", 32'(bus2.done), 32'h0);
        check("rstmid busy after", 32'(bus2.busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
